instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sequential instruction-fetch front end. It is the producer side of the control decoder's instruction interface.
- Holds the PC and reads instruction words from instruction memory over a req/ack handshake with variable latency.
- Presents each word with valid/ready, plus the packed 11-bit field the control decoder consumes.
- Accepts branch redirects, which the datapath forms from the decoder's Branch output and the ALU zero flag.

Parameters:
- XLEN, 32, width of PC, address and instruction word.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  memory read request.
- imem_addr  out  XLEN  read address; stable while imem_req=1.
- imem_ack  in  1  read data valid; may assert in the same cycle as imem_req.
- imem_rdata  in  XLEN  instruction word, sampled when imem_ack=1.
- redirect_valid  in  1  branch taken (Branch & zero).
- redirect_pc  in  XLEN  branch target.
- instr_valid  out  1  instr/instr_pc/ctrl_bits are valid.
- instr_ready  in  1  decoder accepts the instruction.
- instr  out  XLEN  fetched instruction word.
- instr_pc  out  XLEN  address of instr.
- ctrl_bits  out  11  {instr[31], instr[14:12], instr[6:0]}; combinational from instr.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, req_addr=0, state=IDLE.
  - imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0.
- States: IDLE, REQ, DROP, HOLD.
- IDLE: entered only from reset. Moves to REQ on the first clock edge after rst_n deasserts.
- Entering REQ: req_addr<=pc. imem_req=1 and imem_addr=req_addr for the whole state.
- REQ without imem_ack: stay in REQ.
- REQ with imem_ack:
  - instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1.
  - pc<=req_addr+PC_STEP, modulo 2^XLEN (wraps to 0).
  - Next state HOLD.
- Fetch latency: ack cycle to instr_valid is 1 cycle. Throughput with zero-wait memory is 1 instruction per 2 cycles.
- HOLD: imem_req=0. instr_valid stays 1 and outputs are frozen until instr_ready=1. On valid&ready: instr_valid<=0, next state REQ.
- Redirect effect: redirect_pc[1:0] is forced to 2'b00 before use.
- Redirect in REQ with no ack:
  - pc<=redirect_pc, next state DROP.
  - imem_req stays 1 on the old req_addr; the handshake is never abandoned.
- Redirect in REQ coinciding with ack: rdata is discarded, instr_valid stays 0, pc<=redirect_pc, next state REQ.
- DROP: holds req until ack. On ack, rdata is discarded and the next state is REQ, using the redirected pc.
- Redirect in DROP: pc is updated again; state is unchanged.
- Redirect in HOLD: instr_valid<=0 next cycle, pc<=redirect_pc, next state REQ. If instr_ready=1 in the same cycle, the handshake counts as completed; the redirect still sets pc.
- Redirect in IDLE: ignored; pc stays RESET_PC.
- Reset mid-transaction: everything returns to reset values immediately. Any outstanding memory ack after reset is ignored, because imem_req is 0.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 32 bits, reset 0.
  - Increments every cycle with imem_req=1 and imem_ack=0, or with instr_valid=1 and instr_ready=0.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and logic are absent. Core behaviour is identical.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, DROP, HOLD}.
  - XLEN and PC_STEP defaults.
  - Opcode constants 7'b1100011 (beq), 7'b0110011 (arithmetic), 7'b0100011 (sw), shared with the control decoder.
  - Function pack_ctrl_bits(instr) returning the 11-bit field.
- One sub-module, fetch_stall_counter (saturating counter), instantiated only under FETCH_STALL_CNT_EN.

Test Plan:
- Reset release with zero-wait memory (ack tied to req) and instr_ready=1:
  - Addresses seen: 0x0, 0x4, 0x8.
  - instr_valid pulses every 2nd cycle.
  - ctrl_bits for 0x00208663 equals {1'b0, 3'b000, 7'b1100011}.
- Memory ack delayed 3 cycles: imem_addr is stable for all 4 req cycles; instr_valid rises exactly 1 cycle after ack.
- instr_ready=0 for 5 cycles in HOLD: instr and instr_pc frozen, imem_req=0, no new request; fetch resumes after ready.
- redirect_valid with redirect_pc=0x103 in HOLD:
  - Held instruction dropped.
  - Next imem_addr=0x100; the following address is 0x104.
- Redirect to 0x40 in REQ, ack 2 cycles later:
  - DROP keeps the old address until ack.
  - No instr_valid for the stale data.
  - Next request to 0x40.
- FETCH_STALL_CNT_EN defined, 3-cycle ack delay and 2-cycle ready backpressure: stall_cnt increases by exactly 5 per instruction. An assert of rst_n=0 mid-REQ clears stall_cnt and imem_req within the same cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, default widths, opcodes and
// the packed control field consumed by the control decoder.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT    = 32;
    localparam int unsigned PC_STEP_DEFAULT = 4;

    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_ARITH = 7'b0110011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        HOLD
    } fetch_state_t;

    function automatic logic [10:0] pack_ctrl_bits(input logic [31:0] word);
        return {word[31], word[14:12], word[6:0]};
    endfunction

endpackage

// File: rtl/fetch_stall_counter.sv
// Saturating 32-bit cycle counter for fetch stalls (memory wait or decoder
// backpressure).
module fetch_stall_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: req/ack memory reader feeding a valid/ready
// instruction port, with branch redirects. FETCH_STALL_CNT_EN adds stall_cnt.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [10:0]     ctrl_bits
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] redir_pc;

    assign redir_pc  = redirect_pc & ~XLEN'(3);
    assign imem_addr = req_addr;
    assign ctrl_bits = pack_ctrl_bits(instr[31:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_addr    <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_addr <= pc;
                    imem_req <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            pc       <= redir_pc;
                            req_addr <= redir_pc;
                            state    <= REQ;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= req_addr;
                            instr_valid <= 1'b1;
                            pc          <= req_addr + XLEN'(PC_STEP);
                            imem_req    <= 1'b0;
                            state       <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Outstanding read must still complete; its data is dropped.
                        pc    <= redir_pc;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        pc       <= redirect_valid ? redir_pc : pc;
                        req_addr <= redirect_valid ? redir_pc : pc;
                        state    <= REQ;
                    end else if (redirect_valid) begin
                        pc <= redir_pc;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc          <= redir_pc;
                        req_addr    <= redir_pc;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        req_addr    <= pc;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic stall_inc;

    assign stall_inc = (imem_req & ~imem_ack) | (instr_valid & ~instr_ready);

    fetch_stall_counter u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, directed redirect and
// reset sequences, and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [10:0] ctrl_bits;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .ctrl_bits      (ctrl_bits)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    typedef struct {
        logic        ack;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic ack, input logic ready, input logic [31:0] rdata,
                                input logic ereq, input logic [31:0] eaddr, input logic ev,
                                input logic [31:0] einstr, input logic [31:0] epc);
        vec_t r;
        r.ack = ack; r.ready = ready; r.rdata = rdata;
        r.exp_req = ereq; r.exp_addr = eaddr; r.exp_valid = ev;
        r.exp_instr = einstr; r.exp_pc = epc;
        return r;
    endfunction

    function automatic logic [10:0] ref_ctrl(input logic [31:0] x);
        return {x[31], x[14:12], x[6:0]};
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns at the negedge just after rst_n is released (DUT in IDLE).
    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall", stall_cnt, 0);
`endif
        rst_n = 1'b1;
    endtask

    // Called at a negedge with the DUT requesting address a.
    task automatic fetch_one(input int unsigned delay, input int unsigned bp,
                             input logic [31:0] a, input logic [31:0] d);
        for (int unsigned i = 0; i <= delay; i++) begin
            chk("f1_req", imem_req, 1);
            chk("f1_addr_stable", imem_addr, a);
            chk("f1_no_valid", instr_valid, 0);
            imem_ack = (i == delay);
            imem_rdata = d;
            instr_ready = 1'b0;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        for (int unsigned i = 0; i <= bp; i++) begin
            chk("f1_valid", instr_valid, 1);
            chk("f1_instr", instr, d);
            chk("f1_pc", instr_pc, a);
            chk("f1_req_low", imem_req, 0);
            instr_ready = (i == bp);
            @(negedge clk);
        end
        instr_ready = 1'b0;
    endtask

    task automatic run_random(input int unsigned ncyc);
        logic [31:0] exp_next, cur, rpc;
        logic        in_flight, discard, req_now, v_now, ack, rdy, rdr;
        int unsigned lat, exp_stall, delivered;
        ent_t        q[$];
        do_reset();
        exp_next = 32'h0; cur = '0; in_flight = 1'b0; discard = 1'b0;
        lat = 0; exp_stall = 0; delivered = 0;
        for (int unsigned n = 0; n < ncyc; n++) begin
            req_now = imem_req;
            v_now = instr_valid;
`ifdef FETCH_STALL_CNT_EN
            chk("rnd_stall", stall_cnt, exp_stall);
`endif
            chk("rnd_req_while_valid", req_now & v_now, 0);
            if (req_now) begin
                if (!in_flight) begin
                    chk("rnd_addr", imem_addr, exp_next);
                    cur = exp_next;
                    in_flight = 1'b1;
                    discard = 1'b0;
                    lat = $urandom_range(0, 3);
                end else begin
                    chk("rnd_addr_stable", imem_addr, cur);
                end
            end
            if (v_now) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_valid", v_now, 0);
                end else begin
                    chk("rnd_instr", instr, q[0].d);
                    chk("rnd_instr_pc", instr_pc, q[0].a);
                    chk("rnd_ctrl", ctrl_bits, ref_ctrl(q[0].d));
                end
            end
            ack = req_now && (lat == 0);
            if (req_now && lat != 0) lat--;
            rdy = ($urandom_range(0, 3) != 0);
            rdr = (req_now || v_now) && ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            imem_ack = ack;
            imem_rdata = ack ? memf(imem_addr) : $urandom;
            instr_ready = rdy;
            redirect_valid = rdr;
            redirect_pc = rpc;
            if ((req_now && !ack) || (v_now && !rdy)) exp_stall++;
            if (req_now && ack) begin
                in_flight = 1'b0;
                if (!discard && !rdr) begin
                    q.push_back({cur, memf(cur)});
                    exp_next = cur + 32'd4;
                end
            end
            if (rdr) begin
                exp_next = {rpc[31:2], 2'b00};
                if (req_now && !ack) discard = 1'b1;
            end
            if (v_now && (rdy || rdr) && q.size() != 0) begin
                void'(q.pop_front());
                if (rdy) delivered++;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        chk("rnd_progress", delivered > 100, 1);
    endtask

    initial begin
        int unsigned exp_stall;
        logic [31:0] s0, s1, s2;
        logic [10:0] beq_ctrl;
        beq_ctrl = {1'b0, 3'b000, OPC_BEQ};

        // ack, ready, rdata | req, addr, valid, instr, pc
        tbl[0]  = mk(0, 1, 32'h0,         0, 32'h00, 0, 32'h0,         32'h00);
        tbl[1]  = mk(1, 1, 32'h0020_8663, 1, 32'h00, 0, 32'h0,         32'h00);
        tbl[2]  = mk(0, 1, 32'h0,         0, 32'h00, 1, 32'h0020_8663, 32'h00);
        tbl[3]  = mk(1, 1, 32'h0020_81B3, 1, 32'h04, 0, 32'h0,         32'h00);
        tbl[4]  = mk(0, 1, 32'h0,         0, 32'h00, 1, 32'h0020_81B3, 32'h04);
        tbl[5]  = mk(1, 1, 32'h0011_2423, 1, 32'h08, 0, 32'h0,         32'h00);
        tbl[6]  = mk(0, 1, 32'h0,         0, 32'h00, 1, 32'h0011_2423, 32'h08);
        tbl[7]  = mk(0, 1, 32'h0,         1, 32'h0C, 0, 32'h0,         32'h00);
        tbl[8]  = mk(0, 1, 32'h0,         1, 32'h0C, 0, 32'h0,         32'h00);
        tbl[9]  = mk(0, 1, 32'h0,         1, 32'h0C, 0, 32'h0,         32'h00);
        tbl[10] = mk(1, 1, 32'h80A5_C0B3, 1, 32'h0C, 0, 32'h0,         32'h00);
        for (int unsigned i = 11; i <= 15; i++)
            tbl[i] = mk(0, 0, 32'h0,      0, 32'h00, 1, 32'h80A5_C0B3, 32'h0C);
        tbl[16] = mk(0, 1, 32'h0,         0, 32'h00, 1, 32'h80A5_C0B3, 32'h0C);
        tbl[17] = mk(1, 1, 32'h0040_006F, 1, 32'h10, 0, 32'h0,         32'h00);
        tbl[18] = mk(0, 1, 32'h0,         0, 32'h00, 1, 32'h0040_006F, 32'h10);

        do_reset();
        exp_stall = 0;
        for (int unsigned i = 0; i < 19; i++) begin
            chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].exp_req);
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_instr", i), instr, tbl[i].exp_instr);
                chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_pc);
                chk($sformatf("tbl%0d_ctrl", i), ctrl_bits, ref_ctrl(tbl[i].exp_instr));
            end
            if (i == 2) chk("tbl_beq_ctrl", ctrl_bits, beq_ctrl);
`ifdef FETCH_STALL_CNT_EN
            chk($sformatf("tbl%0d_stall", i), stall_cnt, exp_stall);
`endif
            imem_ack = tbl[i].ack;
            imem_rdata = tbl[i].rdata;
            instr_ready = tbl[i].ready;
            if ((tbl[i].exp_req && !tbl[i].ack) || (tbl[i].exp_valid && !tbl[i].ready)) exp_stall++;
            @(negedge clk);
        end
        imem_ack = 1'b0;

        // Two fetches with 3-cycle ack delay and 2-cycle backpressure each.
`ifdef FETCH_STALL_CNT_EN
        s0 = stall_cnt;
`else
        s0 = '0;
`endif
        fetch_one(3, 2, 32'h14, 32'h0030_0093);
`ifdef FETCH_STALL_CNT_EN
        s1 = stall_cnt;
`else
        s1 = '0;
`endif
        fetch_one(3, 2, 32'h18, 32'h0041_8233);
`ifdef FETCH_STALL_CNT_EN
        s2 = stall_cnt;
        chk("stall_delta1", s1 - s0, 5);
        chk("stall_delta2", s2 - s1, 5);
`else
        s2 = '0;
`endif
        chk("after_f1_req", imem_req, 1);
        chk("after_f1_addr", imem_addr, 32'h1C);

        // Redirect to 0x103 while holding an instruction.
        do_reset();
        @(negedge clk);
        chk("hr_req", imem_req, 1);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("hr_valid", instr_valid, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h103; instr_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("hr_dropped", instr_valid, 0);
        chk("hr_req2", imem_req, 1);
        chk("hr_addr", imem_addr, 32'h100);
        imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("hr_valid2", instr_valid, 1);
        chk("hr_pc2", instr_pc, 32'h100);
        chk("hr_instr2", instr, 32'h00A0_0113);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("hr_next_addr", imem_addr, 32'h104);

        // Redirect ignored in IDLE; redirect to 0x40 mid-request, ack 2 cycles later.
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        chk("idle_redir_ignored", imem_addr, 32'h0);
        redirect_pc = 32'h40; imem_ack = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("drop_req1", imem_req, 1);
        chk("drop_addr1", imem_addr, 32'h0);
        chk("drop_valid1", instr_valid, 0);
        @(negedge clk);
        chk("drop_addr2", imem_addr, 32'h0);
        chk("drop_valid2", instr_valid, 0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("drop_stale_valid", instr_valid, 0);
        chk("drop_req_new", imem_req, 1);
        chk("drop_addr_new", imem_addr, 32'h40);
        imem_ack = 1'b1; imem_rdata = 32'h0020_8663;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("drop_valid_new", instr_valid, 1);
        chk("drop_pc_new", instr_pc, 32'h40);
        chk("drop_ctrl_beq", ctrl_bits, beq_ctrl);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("ra_addr", imem_addr, 32'h44);
        // Redirect coinciding with ack: data discarded, refetch at target.
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_pc = 32'h82;
        @(negedge clk);
        imem_ack = 1'b0; redirect_valid = 1'b0;
        chk("ra_valid", instr_valid, 0);
        chk("ra_req", imem_req, 1);
        chk("ra_addr_new", imem_addr, 32'h80);

        // Asynchronous reset in the middle of a request.
        do_reset();
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("mr_req", imem_req, 1);
`ifdef FETCH_STALL_CNT_EN
        chk("mr_stall_pre", stall_cnt, 1);
`endif
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0000;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req_cleared", imem_req, 0);
        chk("mr_addr_cleared", imem_addr, 0);
        chk("mr_valid_cleared", instr_valid, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("mr_stall_cleared", stall_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_ack_ignored", instr_valid, 0);
        chk("mr_restart_req", imem_req, 1);
        chk("mr_restart_addr", imem_addr, 32'h0);
        imem_ack = 1'b0;

        run_random(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
